// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the 16-bit CPU core.
//   OP_CALL / OP_RET / OP_HALT : control-flow opcodes found in instr[15:12]
//   pc_t                       : 16-bit program-counter type
//   seq_state_e                : program-counter sequencer FSM states
package cpu_pkg;

  localparam logic [3:0] OP_CALL = 4'hD;
  localparam logic [3:0] OP_RET  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef logic [15:0] pc_t;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } seq_state_e;

endpackage

// File: rtl/pc_sequencer_ras_stack.sv
// ras_stack: circular return-address LIFO.
//   clk, rst_n  : clock, asynchronous active-low reset
//   push, pop   : one operation per cycle (push wins if both are raised)
//   push_data   : address stored on push
//   top         : most recently pushed address still on the stack
//   empty       : no entries held
//   err         : single-cycle pulse, push while full or pop while empty
// Pushing while full overwrites the oldest entry; popping while empty leaves
// the pointer where it is.
module ras_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] top,
  output logic         empty,
  output logic         err
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_head;   // next slot to write
  logic [CW-1:0] r_count;  // valid entries, saturates at DEPTH
  logic [PW-1:0] w_head_inc;
  logic [PW-1:0] w_head_dec;
  logic          w_full;

  assign w_head_inc = (r_head == PW'(DEPTH - 1)) ? '0 : r_head + 1'b1;
  assign w_head_dec = (r_head == '0) ? PW'(DEPTH - 1) : r_head - 1'b1;
  assign w_full     = (r_count == CW'(DEPTH));
  assign empty      = (r_count == '0);
  assign top        = r_mem[w_head_dec];
  assign err        = (push && w_full) || (!push && pop && empty);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (push) begin
      // The head wraps round, so a push while full lands on the oldest slot.
      r_mem[r_head] <= push_data;
      r_head        <= w_head_inc;
      if (!w_full) r_count <= r_count + 1'b1;
    end else if (pop && !empty) begin
      r_head  <= w_head_dec;
      r_count <= r_count - 1'b1;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter and control-flow sequencer (CALL/RET/HALT,
// taken branches) sitting ahead of instruction fetch.
//   clk, reset     : core clock, asynchronous active-low reset
//   stall          : hold the PC this cycle; no link write, no stack change
//   instr          : instruction at pc (combinational fetch)
//   branch_taken   : execute-stage branch taken, go to branch_target
//   lr_rdata       : current R7, the RET target without a stack
//   pc             : fetch address
//   lr_we/lr_wdata : R7 write for CALL (combinational, pc+1)
//   halted         : registered, 1 once HALT has retired
//   ras_err        : sticky stack overflow/underflow flag
//   dbg_state      : FSM state, for observation only
// Build option PC_SEQ_RAS_EN: adds a RAS_DEPTH-entry return-address stack;
// RET then takes the stack top (lr_rdata when the stack is empty). Without
// it RET always takes lr_rdata and ras_err is 0.
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter int PC_W      = 16,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic [15:0]     instr,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  input  logic [PC_W-1:0] lr_rdata,
  output logic [PC_W-1:0] pc,
  output logic            lr_we,
  output logic [PC_W-1:0] lr_wdata,
  output logic            halted,
  output logic            ras_err,
  output seq_state_e      dbg_state
);

  seq_state_e      r_state;
  seq_state_e      w_next_state;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_next_pc;
  logic [PC_W-1:0] w_pc_inc;
  logic [PC_W-1:0] w_call_tgt;
  logic [PC_W-1:0] w_ret_tgt;
  logic [3:0]      w_op;
  logic            r_halted;
  logic            w_lr_we;
  logic            w_retire;

  assign w_op       = instr[15:12];
  assign w_pc_inc   = r_pc + 1'b1;  // wraps modulo 2^PC_W
  assign w_call_tgt = PC_W'(instr[11:0]);
  // Gated with reset so no link write escapes while reset is held.
  assign w_retire   = (r_state == RUN) && !stall && reset;

`ifdef PC_SEQ_RAS_EN
  logic            w_push;
  logic            w_pop;
  logic [PC_W-1:0] w_ras_top;
  logic            w_ras_empty;
  logic            w_ras_err;
  logic            r_ras_err;

  ras_stack #(
    .DEPTH (RAS_DEPTH),
    .W     (PC_W)
  ) u_ras (
    .clk       (clk),
    .rst_n     (reset),
    .push      (w_push),
    .pop       (w_pop),
    .push_data (w_pc_inc),
    .top       (w_ras_top),
    .empty     (w_ras_empty),
    .err       (w_ras_err)
  );

  assign w_push    = w_retire && (w_op == OP_CALL);
  assign w_pop     = w_retire && (w_op == OP_RET);
  assign w_ret_tgt = w_ras_empty ? lr_rdata : w_ras_top;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_ras_err <= 1'b0;
    else if (w_ras_err) r_ras_err <= 1'b1;
  end

  assign ras_err = r_ras_err;
`else
  assign w_ret_tgt = lr_rdata;
  assign ras_err   = 1'b0;
`endif

  always_comb begin
    w_next_state = r_state;
    w_next_pc    = r_pc;
    w_lr_we      = 1'b0;
    if (w_retire) begin
      // Decoded control opcodes take priority over a taken branch.
      case (w_op)
        OP_HALT: w_next_state = HALTED;
        OP_CALL: begin
          w_next_pc = w_call_tgt;
          w_lr_we   = 1'b1;
        end
        OP_RET:  w_next_pc = w_ret_tgt;
        default: w_next_pc = branch_taken ? branch_target : w_pc_inc;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= RUN;
      r_pc     <= '0;
      r_halted <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_pc     <= w_next_pc;
      r_halted <= (w_next_state == HALTED);
    end
  end

  assign pc        = r_pc;
  assign lr_we     = w_lr_we;
  assign lr_wdata  = w_pc_inc;
  assign halted    = r_halted;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;
  import cpu_pkg::*;

  localparam int RAS_DEPTH = 4;

  logic        clk;
  logic        reset;
  logic        stall;
  logic [15:0] instr;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic [15:0] lr_rdata;
  logic [15:0] pc;
  logic        lr_we;
  logic [15:0] lr_wdata;
  logic        halted;
  logic        ras_err;
  seq_state_e  dbg_state;

  int errors = 0;
  int checks = 0;

  // reference model state
  logic [15:0] m_pc;
  logic        m_halted;
  logic        m_ras_err;
  logic [15:0] m_ras[$];
  logic [15:0] m_r7;
  logic        exp_lr_we;
  logic [15:0] exp_lr_wdata;
  logic        obs_lr_we;
  logic [15:0] obs_lr_wdata;
  logic [15:0] exp_q[$];

  pc_sequencer #(.PC_W(16), .RAS_DEPTH(RAS_DEPTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .instr         (instr),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .lr_rdata      (lr_rdata),
    .pc            (pc),
    .lr_we         (lr_we),
    .lr_wdata      (lr_wdata),
    .halted        (halted),
    .ras_err       (ras_err),
    .dbg_state     (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_pc      = 16'h0000;
    m_halted  = 1'b0;
    m_ras_err = 1'b0;
    m_ras.delete();
  endtask

  // Architectural effect of one clock edge with the given inputs.
  task automatic model_eval(input logic [15:0] ins, input logic st, input logic bt,
                            input logic [15:0] bta, input logic [15:0] lrd);
    logic [15:0] nxt;
    nxt          = m_pc + 16'd1;
    exp_lr_we    = 1'b0;
    exp_lr_wdata = nxt;
    if (!m_halted && !st) begin
      case (ins[15:12])
        4'hF: m_halted = 1'b1;
        4'hD: begin
          exp_lr_we = 1'b1;
          m_r7      = nxt;
`ifdef PC_SEQ_RAS_EN
          if (m_ras.size() == RAS_DEPTH) begin
            m_ras_err = 1'b1;
            void'(m_ras.pop_front());
          end
          m_ras.push_back(nxt);
`endif
          m_pc = {4'h0, ins[11:0]};
        end
        4'hE: begin
`ifdef PC_SEQ_RAS_EN
          if (m_ras.size() != 0) m_pc = m_ras.pop_back();
          else begin
            m_pc      = lrd;
            m_ras_err = 1'b1;
          end
`else
          m_pc = lrd;
`endif
        end
        default: m_pc = bt ? bta : nxt;
      endcase
    end
  endtask

  // driver: called at posedge+1, returns at the next posedge+1
  task automatic cycle(input logic [15:0] ins, input logic st, input logic bt,
                       input logic [15:0] bta, input logic [15:0] lrd);
    instr         = ins;
    stall         = st;
    branch_taken  = bt;
    branch_target = bta;
    lr_rdata      = lrd;
    #3;
    obs_lr_we    = lr_we;
    obs_lr_wdata = lr_wdata;
    model_eval(ins, st, bt, bta, lrd);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset         = 1'b0;
    stall         = 1'b0;
    instr         = 16'h4041;
    branch_taken  = 1'b0;
    branch_target = 16'h0000;
    lr_rdata      = 16'h0000;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    instr = 16'hD005;
    stall = 1'b0;
    branch_taken = 1'b0;
    branch_target = 16'h0000;
    lr_rdata = 16'h0000;
    model_reset();
    @(posedge clk);
    #1;
    checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL reset_pc: got %h expected 0000", pc); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b expected 0", halted); end
    checks++; if (ras_err !== 1'b0) begin errors++; $display("FAIL reset_ras_err: got %b expected 0", ras_err); end
    checks++; if (lr_we !== 1'b0) begin errors++; $display("FAIL reset_lr_we: got %b expected 0", lr_we); end
    checks++; if (dbg_state !== RUN) begin errors++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, RUN); end
    instr = 16'h4041;
    reset = 1'b1;
    for (int i = 1; i <= 2; i++) begin
      cycle(16'h4041, 1'b0, 1'b0, 16'h0000, m_r7);
      checks++; if (pc !== 16'(i)) begin errors++; $display("FAIL reset_step: got %h expected %h", pc, 16'(i)); end
    end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_step_halted: got %b expected 0", halted); end
  endtask

  task automatic test_program();
    logic [15:0] prog [8];
    logic [15:0] exp_pc;
    prog = '{16'h4041, 16'h4082, 16'hD005, 16'h40C9, 16'hF000, 16'h4243, 16'h4484, 16'hE000};
    exp_q = '{16'h0000, 16'h0001, 16'h0002, 16'h0005, 16'h0006, 16'h0007, 16'h0003, 16'h0004};
    do_reset();
    while (exp_q.size() != 0) begin
      exp_pc = exp_q.pop_front();
      checks++; if (pc !== exp_pc) begin errors++; $display("FAIL prog_pc: got %h expected %h", pc, exp_pc); end
      cycle(prog[m_pc[2:0]], 1'b0, 1'b0, 16'h0000, m_r7);
      if (exp_pc == 16'h0002) begin
        checks++; if (obs_lr_we !== 1'b1 || obs_lr_wdata !== 16'h0003) begin
          errors++; $display("FAIL prog_call_link: got we=%b data=%h expected we=1 data=0003", obs_lr_we, obs_lr_wdata);
        end
      end
    end
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL prog_halted: got %b expected 1", halted); end
    for (int i = 0; i < 3; i++) begin
      cycle(16'hD005, 1'b0, 1'b1, 16'h0123, 16'h0456);
      checks++; if (pc !== 16'h0004) begin errors++; $display("FAIL prog_frozen_pc: got %h expected 0004", pc); end
      checks++; if (obs_lr_we !== 1'b0) begin errors++; $display("FAIL prog_frozen_lr_we: got %b expected 0", obs_lr_we); end
    end
    checks++; if (dbg_state !== HALTED) begin errors++; $display("FAIL prog_state: got %0d expected %0d", dbg_state, HALTED); end
  endtask

  task automatic test_stall_call();
    do_reset();
    cycle(16'h4041, 1'b0, 1'b0, 16'h0000, m_r7);
    cycle(16'h4082, 1'b0, 1'b0, 16'h0000, m_r7);
    for (int i = 0; i < 3; i++) begin
      cycle(16'hD005, 1'b1, 1'b0, 16'h0000, m_r7);
      checks++; if (obs_lr_we !== 1'b0) begin errors++; $display("FAIL stall_lr_we: got %b expected 0", obs_lr_we); end
      checks++; if (pc !== 16'h0002) begin errors++; $display("FAIL stall_pc: got %h expected 0002", pc); end
    end
    cycle(16'hD005, 1'b0, 1'b0, 16'h0000, m_r7);
    checks++; if (obs_lr_we !== 1'b1 || obs_lr_wdata !== 16'h0003) begin
      errors++; $display("FAIL stall_release_link: got we=%b data=%h expected we=1 data=0003", obs_lr_we, obs_lr_wdata);
    end
    checks++; if (pc !== 16'h0005) begin errors++; $display("FAIL stall_release_pc: got %h expected 0005", pc); end
`ifdef PC_SEQ_RAS_EN
    // A single stacked entry must hold 3; lr_rdata is deliberately different.
    cycle(16'hE000, 1'b0, 1'b0, 16'h0000, 16'h0BAD);
`else
    cycle(16'hE000, 1'b0, 1'b0, 16'h0000, m_r7);
`endif
    checks++; if (pc !== 16'h0003) begin errors++; $display("FAIL stall_ret_pc: got %h expected 0003", pc); end
    checks++; if (ras_err !== 1'b0) begin errors++; $display("FAIL stall_ras_err: got %b expected 0", ras_err); end
    // HALT under stall must wait for the stall to drop
    cycle(16'hF000, 1'b1, 1'b0, 16'h0000, m_r7);
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL stall_halt_early: got %b expected 0", halted); end
    cycle(16'hF000, 1'b0, 1'b0, 16'h0000, m_r7);
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL stall_halt: got %b expected 1", halted); end
  endtask

  task automatic test_nested_ras();
    logic [15:0] ret_pc [5];
`ifdef PC_SEQ_RAS_EN
    ret_pc = '{16'h0041, 16'h0031, 16'h0021, 16'h0011, 16'h0777};
`else
    ret_pc = '{16'h0777, 16'h0777, 16'h0777, 16'h0777, 16'h0777};
`endif
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      cycle({4'hD, 12'(16 * k)}, 1'b0, 1'b0, 16'h0000, m_r7);
      checks++; if (pc !== 16'(16 * k)) begin errors++; $display("FAIL nest_call_pc: got %h expected %h", pc, 16'(16 * k)); end
    end
`ifdef PC_SEQ_RAS_EN
    checks++; if (ras_err !== 1'b1) begin errors++; $display("FAIL nest_overflow: got %b expected 1", ras_err); end
`else
    checks++; if (ras_err !== 1'b0) begin errors++; $display("FAIL nest_no_ras_err: got %b expected 0", ras_err); end
`endif
    for (int k = 0; k < 5; k++) begin
      cycle(16'hE000, 1'b0, 1'b0, 16'h0000, 16'h0777);
      checks++; if (pc !== ret_pc[k]) begin errors++; $display("FAIL nest_ret_pc: got %h expected %h", pc, ret_pc[k]); end
      checks++; if (pc !== m_pc) begin errors++; $display("FAIL nest_ret_model: got %h expected %h", pc, m_pc); end
    end
  endtask

  task automatic test_wrap_and_async_reset();
    do_reset();
    cycle(16'h4041, 1'b0, 1'b1, 16'hFFFF, m_r7);
    checks++; if (pc !== 16'hFFFF) begin errors++; $display("FAIL wrap_setup: got %h expected ffff", pc); end
    cycle(16'h4041, 1'b0, 1'b0, 16'h0000, m_r7);
    checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL wrap_pc: got %h expected 0000", pc); end
    cycle(16'h4041, 1'b0, 1'b0, 16'h0000, m_r7);
    cycle(16'hF000, 1'b0, 1'b0, 16'h0000, m_r7);
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL async_pre_halted: got %b expected 1", halted); end
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL async_halted_pc: got %h expected 0000", pc); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL async_halted_flag: got %b expected 0", halted); end
    // reset landing mid-CALL
    do_reset();
    cycle(16'h4041, 1'b0, 1'b0, 16'h0000, m_r7);
    instr = 16'hD005;
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    checks++; if (lr_we !== 1'b0) begin errors++; $display("FAIL async_call_lr_we: got %b expected 0", lr_we); end
    checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL async_call_pc: got %h expected 0000", pc); end
  endtask

  task automatic test_branch();
    do_reset();
    cycle(16'h4041, 1'b0, 1'b1, 16'h0010, m_r7);
    checks++; if (pc !== 16'h0010) begin errors++; $display("FAIL branch_pc: got %h expected 0010", pc); end
    cycle(16'hE000, 1'b0, 1'b1, 16'h0010, 16'h0222);
    checks++; if (pc !== 16'h0222) begin errors++; $display("FAIL branch_vs_ret: got %h expected 0222", pc); end
    cycle(16'hD123, 1'b0, 1'b1, 16'h0010, m_r7);
    checks++; if (pc !== 16'h0123) begin errors++; $display("FAIL branch_vs_call: got %h expected 0123", pc); end
    cycle(16'hF000, 1'b0, 1'b1, 16'h0010, m_r7);
    checks++; if (pc !== 16'h0123 || halted !== 1'b1) begin
      errors++; $display("FAIL branch_vs_halt: got pc=%h halted=%b expected pc=0123 halted=1", pc, halted);
    end
  endtask

  task automatic test_random();
    logic [15:0] ins;
    logic [15:0] lrd;
    int          r;
    for (int seg = 0; seg < 4; seg++) begin
      do_reset();
      for (int n = 0; n < 150; n++) begin
        r = $urandom_range(0, 99);
        if (r < 2)       ins = 16'hF000;
        else if (r < 14) ins = {4'hD, 12'($urandom)};
        else if (r < 26) ins = 16'hE000;
        else             ins = {4'($urandom_range(0, 12)), 12'($urandom)};
        lrd = ($urandom_range(0, 3) == 0) ? 16'($urandom) : m_r7;
        cycle(ins, $urandom_range(0, 3) == 0, 1'($urandom), 16'($urandom), lrd);
        checks++; if (obs_lr_we !== exp_lr_we) begin errors++; $display("FAIL rand_lr_we: got %b expected %b", obs_lr_we, exp_lr_we); end
        if (exp_lr_we) begin
          checks++; if (obs_lr_wdata !== exp_lr_wdata) begin errors++; $display("FAIL rand_lr_wdata: got %h expected %h", obs_lr_wdata, exp_lr_wdata); end
        end
        checks++; if (pc !== m_pc) begin errors++; $display("FAIL rand_pc: got %h expected %h", pc, m_pc); end
        checks++; if (halted !== m_halted) begin errors++; $display("FAIL rand_halted: got %b expected %b", halted, m_halted); end
        checks++; if (ras_err !== m_ras_err) begin errors++; $display("FAIL rand_ras_err: got %b expected %b", ras_err, m_ras_err); end
      end
    end
  endtask

  initial begin
    m_r7 = 16'h0000;
    reset = 1'b0;
    #1;
    test_reset();
    test_program();
    test_stall_call();
    test_nested_ras();
    test_wrap_and_async_reset();
    test_branch();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
